// File: rtl/sd_spi_responder_pkg.sv
// Shared definitions for the SPI-mode SD card responder: FSM states,
// command indices, token and response codes, and CRC generator polynomials.
package sd_spi_responder_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_CHECK,
        S_RESP_WAIT,
        S_RESP,
        S_RD_WAIT,
        S_TOKEN,
        S_RD_DATA,
        S_RD_CRC,
        S_WR_HUNT,
        S_WR_DATA,
        S_WR_CRC,
        S_DRESP_WAIT,
        S_DRESP,
        S_BUSY
    } state_t;

    localparam logic [5:0]  CMD_RD        = 6'd17;
    localparam logic [5:0]  CMD_WR        = 6'd24;
    localparam logic [7:0]  TOKEN         = 8'hFE;

    localparam logic [7:0]  R1_OK         = 8'h00;
    localparam logic [7:0]  R1_CRC_ERR    = 8'h08;
    localparam logic [7:0]  R1_ILLEGAL    = 8'h04;
    localparam logic [7:0]  R1_PARAM_ERR  = 8'h40;

    localparam logic [7:0]  DRESP_OK      = 8'h05;
    localparam logic [7:0]  DRESP_CRC_ERR = 8'h0B;

    // Generator polynomials without the implicit top term.
    localparam logic [6:0]  CRC7_POLY     = 7'h09;
    localparam logic [15:0] CRC16_POLY    = 16'h1021;

    function automatic logic [7:0] r1_code(input logic bad_frame,
                                           input logic bad_cmd,
                                           input logic bad_arg);
        if (bad_frame)    return R1_CRC_ERR;
        else if (bad_cmd) return R1_ILLEGAL;
        else if (bad_arg) return R1_PARAM_ERR;
        else              return R1_OK;
    endfunction

endpackage

// File: rtl/sd_spi_responder_crc.sv
// Bit-serial MSB-first CRC with init 0; en together with clr folds din into
// a cleared register so a new CRC can start on the same cycle.
module sd_crc_serial #(
    parameter int             W    = 7,
    parameter logic [W-1:0]   POLY = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] crc
);

    logic [W-1:0] base;
    logic         fb;

    always_comb begin
        base = clr ? '0 : crc;
        fb   = din ^ base[W-1];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in the design sees the pre-edge value of every other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (en) begin
            crc <= {base[W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end else if (clr) begin
            crc <= '0;
        end
    end

endmodule

// File: rtl/sd_spi_responder.sv
// Card side of an SPI-mode SD link: decodes CMD17/CMD24 frames on MOSI, answers
// on a registered MISO and backs the data with a 64-bit synchronous memory port.
module sd_spi_responder
    import sd_spi_responder_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int RESP_UNITS  = 1,
    parameter int DATA_UNITS  = 1,
    parameter int DRESP_UNITS = 0,
    parameter int BUSY_CYC    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    input  logic [63:0]       mem_rdata,
    output logic              mem_wen,
    output logic [63:0]       mem_wdata
);

    localparam int UNIT_MAX = (BUSY_CYC > 64) ? BUSY_CYC : 64;
    localparam int UNIT_W   = $clog2(UNIT_MAX + 1);
    localparam logic [UNIT_W-1:0] RESP_LAST  = UNIT_W'(8 * RESP_UNITS - 1);
    localparam logic [UNIT_W-1:0] DATA_LAST  = UNIT_W'(8 * DATA_UNITS - 1);
    localparam logic [UNIT_W-1:0] DRESP_LAST = UNIT_W'(8 * DRESP_UNITS - 1);
    localparam logic [UNIT_W-1:0] BUSY_LAST  = UNIT_W'(BUSY_CYC - 1);

    state_t             state;
    logic [6:0]         bit_cnt;
    logic [UNIT_W-1:0]  unit_cnt;
    logic [47:0]        frame;
    logic [7:0]         r1;
    logic               is_read;
    logic [63:0]        data_sr;
    logic [15:0]        out_sr;
    logic [15:0]        rx_crc;
    logic               crc_ok;
    logic               ren_d;

    logic [6:0]         crc7;
    logic [15:0]        crc16;
    logic               crc7_clr, crc7_en;
    logic               crc16_clr, crc16_en, crc16_din;

    logic [5:0]         cmd_idx;
    logic [31:0]        cmd_arg;
    logic [7:0]         r1_calc;
    logic               crc_match;
    logic [7:0]         dresp_now;
    logic [7:0]         dresp_reg;

    // NOTE: every always_comb output gets a value on every path, so no latches.
    always_comb begin
        cmd_idx   = frame[45:40];
        cmd_arg   = frame[39:8];
        r1_calc   = r1_code(frame[47] | ~frame[46] | ~frame[0] | (frame[7:1] != crc7),
                            (cmd_idx != CMD_RD) && (cmd_idx != CMD_WR),
                            (cmd_arg >> ADDR_W) != 32'd0);
        crc_match = ({rx_crc[14:0], MOSI} == crc16);
        dresp_now = crc_match ? DRESP_OK : DRESP_CRC_ERR;
        dresp_reg = crc_ok ? DRESP_OK : DRESP_CRC_ERR;
    end

    // CRC7 covers the start bit (taken in IDLE) plus the next 39 frame bits.
    // The read CRC16 is stepped with each data bit as it is loaded into MISO,
    // so the finished value is ready the cycle the CRC field starts.
    always_comb begin
        crc7_clr  = (state == S_IDLE);
        crc7_en   = ((state == S_IDLE) && !MOSI) ||
                    ((state == S_CMD) && (bit_cnt < 7'd39));
        crc16_clr = (state == S_WR_HUNT) ||
                    ((state == S_TOKEN) && (bit_cnt == 7'd7));
        crc16_en  = ((state == S_TOKEN) && (bit_cnt == 7'd7)) ||
                    ((state == S_RD_DATA) && (bit_cnt != 7'd63)) ||
                    (state == S_WR_DATA);
        crc16_din = (state == S_WR_DATA) ? MOSI : data_sr[63];
    end

    sd_crc_serial #(.W(7), .POLY(CRC7_POLY)) u_crc7 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc7_clr),
        .en    (crc7_en),
        .din   (MOSI),
        .crc   (crc7)
    );

    sd_crc_serial #(.W(16), .POLY(CRC16_POLY)) u_crc16 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc16_clr),
        .en    (crc16_en),
        .din   (crc16_din),
        .crc   (crc16)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            MISO      <= 1'b1;
            mem_addr  <= '0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            bit_cnt   <= '0;
            unit_cnt  <= '0;
            frame     <= '0;
            r1        <= '0;
            is_read   <= 1'b0;
            data_sr   <= '0;
            out_sr    <= '0;
            rx_crc    <= '0;
            crc_ok    <= 1'b0;
            ren_d     <= 1'b0;
        end else begin
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
            ren_d   <= mem_ren;
            if (ren_d) data_sr <= mem_rdata;

            case (state)
                S_IDLE: begin
                    MISO <= 1'b1;
                    if (!MOSI) begin
                        frame   <= {frame[46:0], MOSI};
                        bit_cnt <= '0;
                        state   <= S_CMD;
                    end
                end
                S_CMD: begin
                    frame   <= {frame[46:0], MOSI};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 7'd46) state <= S_CHECK;
                end
                S_CHECK: begin
                    r1       <= r1_calc;
                    is_read  <= (cmd_idx == CMD_RD);
                    mem_addr <= cmd_arg[ADDR_W-1:0];
                    mem_ren  <= (r1_calc == R1_OK) && (cmd_idx == CMD_RD);
                    bit_cnt  <= '0;
                    unit_cnt <= '0;
                    if (RESP_UNITS == 0) begin
                        state  <= S_RESP;
                        MISO   <= r1_calc[7];
                        out_sr <= {r1_calc[6:0], 9'd0};
                    end else begin
                        state <= S_RESP_WAIT;
                        MISO  <= 1'b1;
                    end
                end
                S_RESP_WAIT: begin
                    unit_cnt <= unit_cnt + 1'b1;
                    if (unit_cnt == RESP_LAST) begin
                        state   <= S_RESP;
                        MISO    <= r1[7];
                        out_sr  <= {r1[6:0], 9'd0};
                        bit_cnt <= '0;
                    end
                end
                S_RESP: begin
                    if (bit_cnt == 7'd7) begin
                        bit_cnt  <= '0;
                        unit_cnt <= '0;
                        MISO     <= 1'b1;
                        if (r1 != R1_OK) state <= S_IDLE;
                        else if (is_read) state <= S_RD_WAIT;
                        else state <= S_WR_HUNT;
                    end else begin
                        MISO    <= out_sr[15];
                        out_sr  <= {out_sr[14:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    unit_cnt <= unit_cnt + 1'b1;
                    if (unit_cnt == DATA_LAST) begin
                        state   <= S_TOKEN;
                        MISO    <= TOKEN[7];
                        out_sr  <= {TOKEN[6:0], 9'd0};
                        bit_cnt <= '0;
                    end
                end
                S_TOKEN: begin
                    if (bit_cnt == 7'd7) begin
                        state   <= S_RD_DATA;
                        MISO    <= data_sr[63];
                        data_sr <= {data_sr[62:0], 1'b0};
                        bit_cnt <= '0;
                    end else begin
                        MISO    <= out_sr[15];
                        out_sr  <= {out_sr[14:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (bit_cnt == 7'd63) begin
                        state   <= S_RD_CRC;
                        MISO    <= crc16[15];
                        out_sr  <= {crc16[14:0], 1'b0};
                        bit_cnt <= '0;
                    end else begin
                        MISO    <= data_sr[63];
                        data_sr <= {data_sr[62:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_RD_CRC: begin
                    if (bit_cnt == 7'd15) begin
                        state <= S_IDLE;
                        MISO  <= 1'b1;
                    end else begin
                        MISO    <= out_sr[15];
                        out_sr  <= {out_sr[14:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_WR_HUNT: begin
                    MISO <= 1'b1;
                    if (!MOSI) begin
                        state   <= S_WR_DATA;
                        bit_cnt <= '0;
                    end
                end
                S_WR_DATA: begin
                    data_sr <= {data_sr[62:0], MOSI};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 7'd63) begin
                        state   <= S_WR_CRC;
                        bit_cnt <= '0;
                    end
                end
                S_WR_CRC: begin
                    rx_crc  <= {rx_crc[14:0], MOSI};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 7'd15) begin
                        crc_ok   <= crc_match;
                        bit_cnt  <= '0;
                        unit_cnt <= '0;
                        if (DRESP_UNITS == 0) begin
                            state  <= S_DRESP;
                            MISO   <= dresp_now[7];
                            out_sr <= {dresp_now[6:0], 9'd0};
                        end else begin
                            state <= S_DRESP_WAIT;
                            MISO  <= 1'b1;
                        end
                    end
                end
                S_DRESP_WAIT: begin
                    unit_cnt <= unit_cnt + 1'b1;
                    if (unit_cnt == DRESP_LAST) begin
                        state   <= S_DRESP;
                        MISO    <= dresp_reg[7];
                        out_sr  <= {dresp_reg[6:0], 9'd0};
                        bit_cnt <= '0;
                    end
                end
                S_DRESP: begin
                    if (bit_cnt == 7'd7) begin
                        state    <= S_BUSY;
                        MISO     <= 1'b0;
                        unit_cnt <= '0;
                        mem_wen  <= crc_ok;
                        if (crc_ok) mem_wdata <= data_sr;
                    end else begin
                        MISO    <= out_sr[15];
                        out_sr  <= {out_sr[14:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_BUSY: begin
                    MISO     <= 1'b0;
                    unit_cnt <= unit_cnt + 1'b1;
                    if (unit_cnt == BUSY_LAST) begin
                        state <= S_IDLE;
                        MISO  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    MISO  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Scoreboard bench for sd_spi_responder: a driver issues SD frames and pushes the
// expected MISO fields; a monitor decodes MISO and memory strobes and compares.
module tb_sd_spi_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MOSI = 1'b1;
    logic        MISO;
    logic [15:0] mem_addr;
    logic        mem_ren;
    logic [63:0] mem_rdata = '0;
    logic        mem_wen;
    logic [63:0] mem_wdata;

    sd_spi_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .mem_addr  (mem_addr),
        .mem_ren   (mem_ren),
        .mem_rdata (mem_rdata),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    typedef enum {K_R1, K_READ, K_DRESP, K_QUIET} kind_t;
    typedef struct {
        kind_t       kind;
        logic [63:0] val;
        logic [15:0] crc;
        int          n;
    } exp_t;
    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ren_cnt  = 0;
    bit   mon_busy = 0;
    logic [63:0] mem [0:255];

    localparam logic [63:0] RD_DATA = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] WR_DATA = 64'hDEAD_BEEF_CAFE_F00D;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference CRC by polynomial long division of msg * x^w by the full generator.
    function automatic logic [15:0] crc_div(input logic [79:0] msg, input int nbits,
                                            input int w, input logic [16:0] gen);
        logic [95:0] v;
        logic [16:0] mask;
        v = 96'(msg) << w;
        for (int i = nbits + w - 1; i >= w; i--)
            if (v[i]) v = v ^ (96'(gen) << (i - w));
        mask = (17'h1 << w) - 17'd1;
        return 16'(v[16:0] & mask);
    endfunction

    function automatic logic [15:0] crc16_of(input logic [63:0] d);
        return crc_div(80'(d), 64, 16, 17'h11021);
    endfunction

    // Memory model: 1-cycle read latency, write on strobe.
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_addr[7:0]];
    end

    // Memory strobe monitor.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (mem_ren) ren_cnt++;
            if (mem_wen) begin
                if (wr_q.size() == 0) begin
                    check("mem_wen_unexpected", 64'(mem_wen), 64'd0);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(w.addr));
                    check("wr_data", mem_wdata, w.data);
                end
            end
        end
    end

    task automatic hunt_low(input int limit, output logic found, output int ones);
        found = 1'b0;
        ones  = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (MISO == 1'b0) begin
                found = 1'b1;
                break;
            end
            ones++;
        end
    endtask

    task automatic recv_bits(input int n, output logic [63:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v = {v[62:0], MISO};
        end
    endtask

    // MISO monitor: pops the next expected field and decodes it from the line.
    initial begin
        exp_t        it;
        logic        found;
        int          ones;
        int          cnt;
        logic [63:0] v;
        forever begin
            while (exp_q.size() == 0) @(negedge clk);
            mon_busy = 1;
            it = exp_q.pop_front();
            case (it.kind)
                K_R1: begin
                    hunt_low(400, found, ones);
                    check("r1_seen", 64'(found), 64'd1);
                    if (found) begin
                        recv_bits(7, v);
                        check("r1", v, it.val);
                    end
                end
                K_READ: begin
                    hunt_low(400, found, ones);
                    check("token_seen", 64'(found), 64'd1);
                    if (found) begin
                        check("token_ones", 64'(ones), 64'd15);
                        recv_bits(64, v);
                        check("rd_data", v, it.val);
                        recv_bits(16, v);
                        check("rd_crc16", v, 64'(it.crc));
                        @(negedge clk);
                        check("rd_idle", 64'(MISO), 64'd1);
                    end
                end
                K_DRESP: begin
                    hunt_low(400, found, ones);
                    check("dresp_seen", 64'(found), 64'd1);
                    if (found) begin
                        recv_bits(7, v);
                        check("dresp", v, it.val);
                        cnt = 0;
                        for (int i = 0; i < 200; i++) begin
                            @(negedge clk);
                            if (MISO) break;
                            cnt++;
                        end
                        check("busy_len", 64'(cnt), 64'(it.n));
                    end
                end
                default: begin
                    cnt = 0;
                    repeat (it.n) begin
                        @(negedge clk);
                        if (!MISO) cnt++;
                    end
                    check("quiet_low_cycles", 64'(cnt), 64'd0);
                end
            endcase
            mon_busy = 0;
        end
    end

    task automatic push(input kind_t k, input logic [63:0] val, input logic [15:0] crc, input int n);
        exp_t e;
        e.kind = k;
        e.val  = val;
        e.crc  = crc;
        e.n    = n;
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input logic [79:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            MOSI = bits[i];
        end
    endtask

    task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg, input bit flip_crc);
        logic [39:0] head;
        logic [6:0]  c7;
        head = {2'b01, idx, arg};
        c7   = 7'(crc_div(80'(head), 40, 7, 17'h89));
        if (flip_crc) c7[3] = ~c7[3];
        send_bits(80'({head, c7, 1'b1}), 48);
        MOSI = 1'b1;
    endtask

    task automatic send_write_data(input logic [63:0] d, input bit flip_crc);
        logic [15:0] c16;
        c16 = crc16_of(d);
        if (flip_crc) c16[0] = ~c16[0];
        repeat (25) begin
            @(negedge clk);
            MOSI = 1'b1;
        end
        send_bits(80'(8'hFE), 8);
        send_bits(80'(d), 64);
        send_bits(80'(c16), 16);
        @(negedge clk);
        MOSI = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || mon_busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_in_time", 64'(t < 3000), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] arg, input logic [63:0] d, input bit flip,
                            input logic [7:0] exp_dresp);
        wr_t w;
        push(K_R1, 64'h00, '0, 0);
        push(K_DRESP, 64'(exp_dresp), '0, 16);
        if (!flip) begin
            w.addr = arg[15:0];
            w.data = d;
            wr_q.push_back(w);
        end
        send_frame(6'd24, arg, 1'b0);
        send_write_data(d, flip);
        drain();
    endtask

    initial begin
        int ren_base;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[5] = RD_DATA;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_miso", 64'(MISO), 64'd1);
        check("rst_mem_ren", 64'(mem_ren), 64'd0);
        check("rst_mem_wen", 64'(mem_wen), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Reset asserted mid-way through read data.
        send_frame(6'd17, 32'd5, 1'b0);
        repeat (53) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_miso", 64'(MISO), 64'd1);
        check("midrst_ren", 64'(mem_ren), 64'd0);
        check("midrst_wen", 64'(mem_wen), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_idle_miso", 64'(MISO), 64'd1);

        // CMD17 arg=5: full read.
        ren_base = ren_cnt;
        push(K_R1, 64'h00, '0, 0);
        push(K_READ, RD_DATA, crc16_of(RD_DATA), 0);
        send_frame(6'd17, 32'd5, 1'b0);
        drain();
        check("rd5_ren_pulses", 64'(ren_cnt - ren_base), 64'd1);

        // CMD24 arg=3 good CRC16, then read it back.
        do_write(32'd3, WR_DATA, 1'b0, 8'h05);
        push(K_R1, 64'h00, '0, 0);
        push(K_READ, WR_DATA, crc16_of(WR_DATA), 0);
        send_frame(6'd17, 32'd3, 1'b0);
        drain();

        // CMD24 with CRC16 bit 0 flipped: no write.
        do_write(32'd3, 64'h1111_2222_3333_4444, 1'b1, 8'h0B);

        // CMD17 with a corrupted CRC7 bit.
        ren_base = ren_cnt;
        push(K_R1, 64'h08, '0, 0);
        push(K_QUIET, '0, '0, 120);
        send_frame(6'd17, 32'd5, 1'b1);
        drain();
        check("badcrc_no_ren", 64'(ren_cnt - ren_base), 64'd0);

        // Out-of-range argument followed back-to-back by an unsupported index.
        ren_base = ren_cnt;
        push(K_R1, 64'h40, '0, 0);
        push(K_R1, 64'h04, '0, 0);
        send_frame(6'd17, 32'h0001_0000, 1'b0);
        repeat (18) @(negedge clk);
        send_frame(6'd13, 32'd0, 1'b0);
        drain();
        check("err_no_ren", 64'(ren_cnt - ren_base), 64'd0);

        // CMD24 at the highest in-range address.
        do_write(32'h0000_FFFF, 64'h8000_0000_0000_0001, 1'b0, 8'h05);

        check("all_writes_seen", 64'(wr_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
